tt_um_serial_adder_ctrl: RTL and testbench

Sequencer that drives one shared full-adder cell (sum = a^b^cin, carry = majority) bit-serially. It adds two WIDTH-bit operands captured from the dedicated inputs, LSB first, one bit per clock. It is a Tiny Tapeout user tile with the standard pinout, and it is the sequential counterpart to the combinational 3-input XOR sum cell. It exposes a start/done handshake and holds the (WIDTH+1)-bit result until it is released.

---
 rtl/serial_add_pkg.sv | 26 ++
 rtl/full_adder_cell.sv | 15 +
 rtl/tt_um_serial_adder_ctrl.sv | 152 +++++++++++++++
 tb/tb_tt_um_serial_adder_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared encodings, pin indices and full-adder helper functions for the serial adder tile.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int START_BIT  = 0;
  localparam int SUB_BIT    = 1;
  localparam int BUSY_BIT   = 5;
  localparam int DONE_BIT   = 6;
  localparam int SERBIT_BIT = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  function automatic logic xor3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single combinational full-adder cell shared by every bit position of the serial adder.
module full_adder_cell
  import serial_add_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = xor3(i_a, i_b, i_cin);
  assign o_cout = maj3(i_a, i_b, i_cin);

endmodule

// File: rtl/tt_um_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer (Tiny Tapeout tile) with start/done handshake.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module tt_um_serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [1:0] LAST_CNT = 2'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH:0]     r_result;
  logic               r_carry;
  logic [1:0]         r_cnt;

  logic               w_start;
  logic               w_last;
  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_b_cap;
  logic               w_cin_cap;
  logic [WIDTH-1:0]   w_res_lo;
  logic [7:0]         w_uo;
  logic               w_unused;

  assign w_start  = uio_in[START_BIT];
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_unused = &{1'b0, ena, ui_in, uio_in};

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is A + ~B + 1; the carry-out then reads as "no borrow".
  assign w_b_cap   = uio_in[SUB_BIT] ? ~ui_in[4 +: WIDTH] : ui_in[4 +: WIDTH];
  assign w_cin_cap = uio_in[SUB_BIT];
`else
  assign w_b_cap   = ui_in[4 +: WIDTH];
  assign w_cin_cap = 1'b0;
`endif

  full_adder_cell u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the unused 2'b11 code falls back to IDLE
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (w_start) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result shifts right with the new sum bit entering at the top of the sum field
  always_comb begin
    w_res_lo            = r_result[WIDTH-1:0] >> 1;
    w_res_lo[WIDTH-1]   = w_sum;
  end

  // Operand capture and bit-serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_a_sr   <= ui_in[WIDTH-1:0];
            r_b_sr   <= w_b_cap;
            r_result <= '0;
            r_carry  <= w_cin_cap;
            r_cnt    <= 2'd0;
          end
        end
        ST_RUN: begin
          r_a_sr               <= r_a_sr >> 1;
          r_b_sr               <= r_b_sr >> 1;
          r_result[WIDTH-1:0]  <= w_res_lo;
          r_carry              <= w_cout;
          r_cnt                <= r_cnt + 2'd1;
          if (w_last) begin
            r_result[WIDTH] <= w_cout;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Output pin packing
  always_comb begin
    w_uo              = 8'h00;
    w_uo[WIDTH:0]     = r_result;
    w_uo[BUSY_BIT]    = (r_state == ST_RUN);
    w_uo[DONE_BIT]    = (r_state == ST_DONE);
    w_uo[SERBIT_BIT]  = (r_state == ST_RUN) ? w_sum : 1'b0;
  end

  assign uo_out  = w_uo;
  assign uio_out = {r_state, r_cnt, 4'h0};
  assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_serial_adder_ctrl.sv
// Scoreboard bench for tt_um_serial_adder_ctrl: directed handshake cases plus random operations.
module tb_tt_um_serial_adder_ctrl;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit prev_done = 1'b0;

  always #5 clk = ~clk;

  tt_um_serial_adder_ctrl #(.WIDTH(W)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: unsigned add, or A-B offset by 2^W so the top bit means A>=B
  function automatic int model(input int a, input int b, input bit sub);
    int r;
    r = a + b;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) r = a - b + (1 << W);
`else
    if (sub) r = a + b;
`endif
    return r % (1 << (W + 1));
  endfunction

  // Monitor: every rising done pops one expected result
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (uo_out[6] && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", int'(uo_out[W:0]), e);
        end
      end
      prev_done = uo_out[6];
    end
  end

  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input bit sub);
    ui_in  = {b, a};
    uio_in = {6'b0, sub, 1'b1};
    exp_q.push_back(model(int'(a), int'(b), sub));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uo_out[6]) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit sub, input int hold);
    start_op(a, b, sub);
    for (int i = 0; i < hold; i++) @(negedge clk);
    uio_in[0] = 1'b0;
    wait_done();
    @(negedge clk);
    chk("back_to_idle", int'(uio_out[7:6]), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_uo_out", int'(uo_out), 0);
    chk("rst_uio_out", int'(uio_out), 0);
    chk("rst_uio_oe", int'(uio_oe), 8'hF0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_uo_out", int'(uo_out), 0);

    // 5 + 6, one-cycle start: busy for W cycles with counter stepping
    start_op(4'd5, 4'd6, 1'b0);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      uio_in[0] = 1'b0;
      chk("run_busy", int'(uo_out[5]), 1);
      chk("run_cnt", int'(uio_out[5:4]), k);
      chk("run_state", int'(uio_out[7:6]), 1);
      chk("run_done_low", int'(uo_out[6]), 0);
    end
    @(negedge clk);
    chk("t1_done", int'(uo_out[6]), 1);
    chk("t1_state", int'(uio_out[7:6]), 2);
    chk("t1_busy_low", int'(uo_out[5]), 0);
    chk("t1_serbit_low", int'(uo_out[7]), 0);
    chk("t1_result", int'(uo_out[4:0]), 5'b01011);
    @(negedge clk);
    chk("t1_idle", int'(uio_out[7:6]), 0);
    chk("t1_hold", int'(uo_out[4:0]), 5'b01011);

    // 15 + 15 with start held through DONE
    start_op(4'd15, 4'd15, 1'b0);
    wait_done();
    chk("t2_result", int'(uo_out[4:0]), 5'b11110);
    repeat (3) begin
      @(negedge clk);
      chk("t2_stay_done", int'(uio_out[7:6]), 2);
      chk("t2_no_busy", int'(uo_out[5]), 0);
    end
    uio_in[0] = 1'b0;
    @(negedge clk);
    chk("t2_release", int'(uio_out[7:6]), 0);
    @(negedge clk);
    chk("t2_no_retrigger", int'(uio_out[7:6]), 0);

    // start re-pulsed during RUN with new operands is ignored
    start_op(4'd9, 4'd4, 1'b0);
    @(negedge clk);
    uio_in[0] = 1'b0;
    @(negedge clk);
    ui_in     = 8'hFF;
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
    wait_done();
    chk("t3_result", int'(uo_out[4:0]), 13);
    @(negedge clk);

    // reset in the middle of RUN aborts the operation
    start_op(4'd9, 4'd2, 1'b0);
    @(negedge clk);
    uio_in[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_uo_out", int'(uo_out), 0);
    chk("abort_uio_out", int'(uio_out), 0);
    chk("abort_uio_oe", int'(uio_oe), 8'hF0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", int'(uio_out[7:6]), 0);
    run_op(4'd3, 4'd4, 1'b0, 1);
    chk("t4_result", int'(uo_out[4:0]), 5'b00111);

    // sub request: honoured only when the subtract option is built in
    run_op(4'd7, 4'd3, 1'b1, 1);
`ifdef SERIAL_ADD_SUB_EN
    chk("sub_7_3", int'(uo_out[4:0]), 5'b10100);
    run_op(4'd3, 4'd7, 1'b1, 1);
    chk("sub_3_7", int'(uo_out[4:0]), 5'b01100);
`else
    chk("nosub_7_3", int'(uo_out[4:0]), 5'b01010);
`endif

    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
